// File: rtl/bitty_pkg.sv
// bitty_pkg: shared fetch-state encoding and default widths for the bitty fetch path
package bitty_pkg;
    localparam int BITTY_INST_W = 16;
    localparam int BITTY_ADDR_W = 8;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        ISSUE = 2'd3
    } fetch_state_t;
endpackage

// File: rtl/bitty_pc.sv
// bitty_pc: program counter with async active-low clear, enable and increment/load select
module bitty_pc
    import bitty_pkg::*;
#(
    parameter int ADDR_W = BITTY_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc
);
    // increment wraps modulo 2**ADDR_W through natural truncation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc <= '0;
        else if (en) pc <= load ? load_val : pc + 1'b1;
    end
endmodule

// File: rtl/bitty_fetch_unit.sv
// bitty_fetch_unit: PC + sync-memory fetch, holds instruction until done
// optional branch load on done enabled by macro BITTY_FETCH_BRANCH_EN
module bitty_fetch_unit
    import bitty_pkg::*;
#(
    parameter int ADDR_W = BITTY_ADDR_W,
    parameter int INST_W = BITTY_INST_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INST_W-1:0] mem_rdata,
    output logic [INST_W-1:0] instruction,
    output logic              inst_valid,
    input  logic              done,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc
);
    fetch_state_t state;
    logic advance;
    logic do_branch;
    assign advance  = (state == ISSUE) && done;
    assign mem_addr = pc;
`ifdef BITTY_FETCH_BRANCH_EN
    assign do_branch = branch_taken;
`else
    logic unused_branch;
    assign do_branch     = 1'b0;
    assign unused_branch = branch_taken;
`endif
    bitty_pc #(.ADDR_W(ADDR_W)) u_pc (
        .clk      (clk),
        .reset    (reset),
        .en       (advance),
        .load     (do_branch),
        .load_val (branch_target),
        .pc       (pc)
    );
    // mem_rd_en is registered so it is high exactly for the one FETCH cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            mem_rd_en   <= 1'b0;
            instruction <= '0;
            inst_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (run) begin
                    state     <= FETCH;
                    mem_rd_en <= 1'b1;
                end
                FETCH: begin
                    state     <= WAIT;
                    mem_rd_en <= 1'b0;
                end
                WAIT: begin
                    state       <= ISSUE;
                    instruction <= mem_rdata;
                    inst_valid  <= 1'b1;
                end
                ISSUE: if (done) begin
                    state      <= run ? FETCH : IDLE;
                    mem_rd_en  <= run;
                    inst_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
